memory_stage: RTL
=================

// Module: memory_stage
// PURPOSE
//  Fourth pipeline stage, directly downstream of execute. Consumes the buffered exe results, performs
//  load/store on a req/ack data bus (byte enables, load sign/zero extension, misalignment trap),
//  selects the writeback value, registers a one-cycle branch/jump redirect, and stalls the pipe during bus waits.
// PARAMETERS
//  none (widths fixed by RV32I: 32b data, 30b word PC)
// PORTS
//  clk             in   1   clock; all state on rising edge
//  sync_rst_n      in   1   reset, synchronous, active-low
//  clk_en          in   1   global advance enable; low freezes all state and outputs
//  ctr_in          in   6   [0]mem_read [1]mem_write [2]reg_write [4:3]wb_sel(0 alu,1 mem,2 inc_pc) [5]rsvd
//  inst_in         in   32  instruction (fn3=[14:12], rd=[11:7])
//  alu_in          in   32  ALU result: load/store byte address or writeback data
//  inc_pc_in       in   30  PC+1 (word), link value for JAL/JALR
//  rs2_data_in     in   32  store data
//  branch_in       in   1   branch taken / jump
//  dbus_req        out  1   bus request, held until ack
//  dbus_we         out  1   1 = store
//  dbus_addr       out  30  word address
//  dbus_be         out  4   byte enables
//  dbus_wdata      out  32  lane-replicated store data
//  dbus_ack        in   1   transfer done this cycle; rdata valid for loads
//  dbus_rdata      in   32  load word
//  mem_stall       out  1   upstream must hold its buffers (not advance) this cycle
//  mem_rd_address  out  5   rd of instruction at inputs (hazard/forward detection)
//  mem_writes_rd   out  1   ctr_in[2] && rd!=0
//  wb_valid        out  1   wb_* hold a retiring instruction
//  wb_reg_write    out  1   write regfile
//  wb_rd           out  5   destination register
//  wb_data         out  32  writeback value
//  redirect_valid  out  1   one-cycle pulse: fetch must jump
//  redirect_pc     out  30  target = alu_in[31:2]
//  misaligned_exc  out  1   one-cycle pulse: misaligned access trapped
// BEHAVIOUR
//  Reset: state=IDLE; dbus_req, wb_valid, wb_reg_write, redirect_valid, misaligned_exc = 0; other regs undefined-safe (0).
//  Reset mid-BUSY: request dropped next edge, transfer abandoned, no writeback.
//  memop = ctr_in[0]|ctr_in[1]. mis = (fn3[1:0]==01 && a[0]) || (fn3[1:0]==10 && a[1:0]!=0), a=alu_in.
//  FSM (advances only when clk_en):
//   IDLE, !memop: wb_* <= {reg_write, rd, sel(alu_in | inc_pc_in<<2)}, wb_valid<=1; redirect_valid<=branch_in,
//     redirect_pc<=alu_in[31:2]. Latency 1 cycle.
//   IDLE, memop && mis: no bus access; misaligned_exc<=1, wb_valid<=1, wb_reg_write<=0; stay IDLE.
//   IDLE, memop && !mis: capture addr/we/be/wdata/fn3/rd/a[1:0] -> BUSY; wb_valid<=0.
//   BUSY: dbus_req=1, outputs from captured regs, inputs ignored. On dbus_ack: load -> wb_data<=extend(rdata);
//     store -> wb_reg_write<=0; wb_valid<=1; -> IDLE. Minimum memory latency 2 cycles.
//  mem_stall (comb) = (IDLE && memop && !mis) || (BUSY && !dbus_ack).
//  Store: SB be=0001<<a[1:0], wdata={4{rs2[7:0]}}; SH be=0011<<a[1], {2{rs2[15:0]}}; SW be=1111.
//  Load: byte/half lane selected by captured a[1:0]; fn3 000 LB sext, 001 LH sext, 010 LW, 100 LBU, 101 LHU zext;
//    other fn3 -> 0.
//  dbus_ack while IDLE is ignored. clk_en low in BUSY: dbus_req stays 1; ack ignored (bus must hold until seen).
//  redirect_valid/misaligned_exc are single-cycle pulses, cleared on the next enabled edge.
//  wb_rd forced 0 when wb_reg_write=0.
// STRUCTURE
//  srv1_pkg: ctr bit indices, wb_sel_t enum, LB..LHU/SB..SW fn3 constants, mem_state_t {IDLE,BUSY}.
//  Sub-module mem_load_align (comb): rdata, a[1:0], fn3 -> extended 32b load value.
// TESTING
//  SW x=0xDEADBEEF @0x100, ack 1st BUSY cycle -> addr=0x40, be=1111, we=1, stall 1 cycle only, no regfile write.
//  LB @0x103, rdata=0x80FF_FF_FF, ack after 3 waits -> stall 4 cycles, wb_data=0xFFFFFF80, wb_rd=rd.
//  LHU @0x102 rdata=0x8001_0000 -> wb_data=0x00008001; SH @0x102 rs2=0x1234 -> be=1100, wdata=0x12341234.
//  LW @0x102 -> no dbus_req ever, misaligned_exc pulse 1 cycle, wb_reg_write=0, no stall.
//  JAL branch_in=1 alu_in=0x200 inc_pc_in=0x41 -> redirect_valid 1 cycle, redirect_pc=0x80, wb_data=0x104.
//  Reset low during BUSY -> next cycle dbus_req=0, IDLE, wb_valid=0; late ack ignored.

Source files
------------

// File: rtl/srv1_pkg.sv
// ============================================================================
//  srv1_pkg : shared control-bit indices, enums and fn3 codes for the memory stage
//  Rev 1.0
// ============================================================================
`default_nettype none

package srv1_pkg;

   localparam int unsigned CTR_MEM_READ  = 0;
   localparam int unsigned CTR_MEM_WRITE = 1;
   localparam int unsigned CTR_REG_WRITE = 2;
   localparam int unsigned CTR_WB_SEL_LO = 3;
   localparam int unsigned CTR_WB_SEL_HI = 4;

   typedef enum logic [1:0] {
      WB_ALU    = 2'd0,
      WB_MEM    = 2'd1,
      WB_INC_PC = 2'd2
   } wb_sel_t;

   typedef enum logic {
      MEM_IDLE = 1'b0,
      MEM_BUSY = 1'b1
   } mem_state_t;

   localparam logic [2:0] FN3_LB  = 3'b000;
   localparam logic [2:0] FN3_LH  = 3'b001;
   localparam logic [2:0] FN3_LW  = 3'b010;
   localparam logic [2:0] FN3_LBU = 3'b100;
   localparam logic [2:0] FN3_LHU = 3'b101;
   localparam logic [2:0] FN3_SB  = 3'b000;
   localparam logic [2:0] FN3_SH  = 3'b001;
   localparam logic [2:0] FN3_SW  = 3'b010;

   // Size is encoded in fn3[1:0] for both loads and stores.
   function automatic logic is_misaligned(input logic [2:0] fn3, input logic [1:0] a);
      return ((fn3[1:0] == 2'b01) && a[0]) || ((fn3[1:0] == 2'b10) && (a != 2'b00));
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_load_align.sv
// ============================================================================
//  mem_load_align : selects the byte/half lane of a load word and extends it
//  Rev 1.0
// ============================================================================
`default_nettype none

module mem_load_align
   import srv1_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  fn3,
   output logic [31:0] load_data
);

   logic [31:0] shifted;

   always_comb begin
      shifted = rdata >> {addr_lo, 3'b000};
      case (fn3)
         FN3_LB:  load_data = {{24{shifted[7]}}, shifted[7:0]};
         FN3_LH:  load_data = {{16{shifted[15]}}, shifted[15:0]};
         FN3_LW:  load_data = rdata;
         FN3_LBU: load_data = {24'd0, shifted[7:0]};
         FN3_LHU: load_data = {16'd0, shifted[15:0]};
         default: load_data = 32'd0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/memory_stage.sv
// ============================================================================
//  memory_stage : load/store over a req/ack bus, writeback select, branch redirect
//  Rev 1.0
// ============================================================================
`default_nettype none

module memory_stage
   import srv1_pkg::*;
(
   input  logic        clk,
   input  logic        sync_rst_n,
   input  logic        clk_en,
   input  logic [5:0]  ctr_in,
   input  logic [31:0] inst_in,
   input  logic [31:0] alu_in,
   input  logic [29:0] inc_pc_in,
   input  logic [31:0] rs2_data_in,
   input  logic        branch_in,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [29:0] dbus_addr,
   output logic [3:0]  dbus_be,
   output logic [31:0] dbus_wdata,
   input  logic        dbus_ack,
   input  logic [31:0] dbus_rdata,
   output logic        mem_stall,
   output logic [4:0]  mem_rd_address,
   output logic        mem_writes_rd,
   output logic        wb_valid,
   output logic        wb_reg_write,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        redirect_valid,
   output logic [29:0] redirect_pc,
   output logic        misaligned_exc
);

   mem_state_t  state_q, state_d;
   logic        wb_valid_q, wb_valid_d;
   logic        wb_reg_write_q, wb_reg_write_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        redirect_valid_q, redirect_valid_d;
   logic [29:0] redirect_pc_q, redirect_pc_d;
   logic        misaligned_exc_q, misaligned_exc_d;
   logic [29:0] addr_q, addr_d;
   logic        we_q, we_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  fn3_q, fn3_d;
   logic [4:0]  rd_q, rd_d;
   logic [1:0]  lane_q, lane_d;
   logic        load_wr_q, load_wr_d;

   logic [2:0]  fn3;
   logic [4:0]  rd;
   logic        memop;
   logic        mis;
   logic        reg_write;
   wb_sel_t     wb_sel;
   logic [31:0] sel_data;
   logic [3:0]  store_be;
   logic [31:0] store_wdata;
   logic [31:0] load_data;
   logic        unused_bits;

   assign fn3       = inst_in[14:12];
   assign rd        = inst_in[11:7];
   assign memop     = ctr_in[CTR_MEM_READ] | ctr_in[CTR_MEM_WRITE];
   assign mis       = is_misaligned(fn3, alu_in[1:0]);
   assign reg_write = ctr_in[CTR_REG_WRITE];
   assign wb_sel    = wb_sel_t'(ctr_in[CTR_WB_SEL_HI:CTR_WB_SEL_LO]);
   assign unused_bits = ^{ctr_in[5], inst_in[31:15], inst_in[6:0]};

   always_comb begin
      case (wb_sel)
         WB_INC_PC: sel_data = {inc_pc_in, 2'b00};
         default:   sel_data = alu_in;
      endcase
      case (fn3[1:0])
         2'b00: begin
            store_be    = 4'b0001 << alu_in[1:0];
            store_wdata = {4{rs2_data_in[7:0]}};
         end
         2'b01: begin
            store_be    = 4'b0011 << {alu_in[1], 1'b0};
            store_wdata = {2{rs2_data_in[15:0]}};
         end
         default: begin
            store_be    = 4'b1111;
            store_wdata = rs2_data_in;
         end
      endcase
   end

   mem_load_align u_load_align (
      .rdata     (dbus_rdata),
      .addr_lo   (lane_q),
      .fn3       (fn3_q),
      .load_data (load_data)
   );

   always_comb begin
      state_d          = state_q;
      wb_valid_d       = wb_valid_q;
      wb_reg_write_d   = wb_reg_write_q;
      wb_rd_d          = wb_rd_q;
      wb_data_d        = wb_data_q;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = redirect_pc_q;
      misaligned_exc_d = 1'b0;
      addr_d           = addr_q;
      we_d             = we_q;
      be_d             = be_q;
      wdata_d          = wdata_q;
      fn3_d            = fn3_q;
      rd_d             = rd_q;
      lane_d           = lane_q;
      load_wr_d        = load_wr_q;

      case (state_q)
         MEM_IDLE: begin
            if (!memop) begin
               wb_valid_d       = 1'b1;
               wb_reg_write_d   = reg_write;
               wb_rd_d          = reg_write ? rd : 5'd0;
               wb_data_d        = sel_data;
               redirect_valid_d = branch_in;
               redirect_pc_d    = alu_in[31:2];
            end else if (mis) begin
               misaligned_exc_d = 1'b1;
               wb_valid_d       = 1'b1;
               wb_reg_write_d   = 1'b0;
               wb_rd_d          = 5'd0;
            end else begin
               state_d        = MEM_BUSY;
               wb_valid_d     = 1'b0;
               wb_reg_write_d = 1'b0;
               wb_rd_d        = 5'd0;
               addr_d         = alu_in[31:2];
               we_d           = ctr_in[CTR_MEM_WRITE];
               be_d           = store_be;
               wdata_d        = store_wdata;
               fn3_d          = fn3;
               rd_d           = rd;
               lane_d         = alu_in[1:0];
               load_wr_d      = reg_write & ~ctr_in[CTR_MEM_WRITE];
            end
         end
         MEM_BUSY: begin
            if (dbus_ack) begin
               state_d    = MEM_IDLE;
               wb_valid_d = 1'b1;
               if (!we_q) begin
                  wb_reg_write_d = load_wr_q;
                  wb_rd_d        = load_wr_q ? rd_q : 5'd0;
                  wb_data_d      = load_data;
               end else begin
                  wb_reg_write_d = 1'b0;
                  wb_rd_d        = 5'd0;
               end
            end
         end
         default: state_d = MEM_IDLE;
      endcase
   end

   // clk_en low freezes everything, including a pending bus ack.
   always_ff @(posedge clk) begin
      if (!sync_rst_n) begin
         state_q          <= MEM_IDLE;
         wb_valid_q       <= 1'b0;
         wb_reg_write_q   <= 1'b0;
         wb_rd_q          <= 5'd0;
         wb_data_q        <= 32'd0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= 30'd0;
         misaligned_exc_q <= 1'b0;
         addr_q           <= 30'd0;
         we_q             <= 1'b0;
         be_q             <= 4'd0;
         wdata_q          <= 32'd0;
         fn3_q            <= 3'd0;
         rd_q             <= 5'd0;
         lane_q           <= 2'd0;
         load_wr_q        <= 1'b0;
      end else if (clk_en) begin
         state_q          <= state_d;
         wb_valid_q       <= wb_valid_d;
         wb_reg_write_q   <= wb_reg_write_d;
         wb_rd_q          <= wb_rd_d;
         wb_data_q        <= wb_data_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         misaligned_exc_q <= misaligned_exc_d;
         addr_q           <= addr_d;
         we_q             <= we_d;
         be_q             <= be_d;
         wdata_q          <= wdata_d;
         fn3_q            <= fn3_d;
         rd_q             <= rd_d;
         lane_q           <= lane_d;
         load_wr_q        <= load_wr_d;
      end
   end

   assign dbus_req       = (state_q == MEM_BUSY);
   assign dbus_we        = (state_q == MEM_BUSY) & we_q;
   assign dbus_addr      = addr_q;
   assign dbus_be        = be_q;
   assign dbus_wdata     = wdata_q;
   assign mem_stall      = ((state_q == MEM_IDLE) && memop && !mis) ||
                           ((state_q == MEM_BUSY) && !dbus_ack);
   assign mem_rd_address = rd;
   assign mem_writes_rd  = reg_write && (rd != 5'd0);
   assign wb_valid       = wb_valid_q;
   assign wb_reg_write   = wb_reg_write_q;
   assign wb_rd          = wb_rd_q;
   assign wb_data        = wb_data_q;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign misaligned_exc = misaligned_exc_q;

endmodule

`default_nettype wire
